// File: rtl/mips_mem_responder.sv
// Unified instruction/data word RAM for the multi-cycle MIPS core, behind a
// request/response handshake with WAIT_CYCLES wait states. Optional: MIPS_MEM_ALIGN_CHECK_EN.
module mips_mem_responder #(
  parameter int BIT_WIDTH   = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BIT_WIDTH-1:0] resp_rdata
`ifdef MIPS_MEM_ALIGN_CHECK_EN
  ,
  output logic                 resp_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  function automatic logic addr_err(input logic [BIT_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr[BIT_WIDTH-1:ADDR_BITS+2] != {(BIT_WIDTH-ADDR_BITS-2){1'b0}});
  endfunction

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [BIT_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [BIT_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic                   resp_err_q, resp_err_d;
  logic [BIT_WIDTH-1:0]   ram_q [DEPTH];

  logic                   req_err_s;
  logic                   access_s;
  logic                   acc_we_s;
  logic [ADDR_BITS-1:0]   acc_idx_s;
  logic [BIT_WIDTH-1:0]   acc_wdata_s;
  logic                   acc_err_s;

`ifdef MIPS_MEM_ALIGN_CHECK_EN
  assign req_err_s = addr_err(req_addr);
  assign resp_err  = resp_err_q;
`else
  logic unused_s;
  assign req_err_s = 1'b0;
  assign unused_s  = addr_err(req_addr) ^ resp_err_q;
`endif

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;

  // Next-state, request latch and access-edge selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    resp_err_d  = resp_err_q;
    access_s    = 1'b0;
    acc_we_s    = we_q;
    acc_idx_s   = idx_q;
    acc_wdata_s = wdata_q;
    acc_err_s   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_BITS+1:2];
          wdata_d = req_wdata;
          err_d   = req_err_s;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the access uses the live request on the accept edge.
            access_s    = 1'b1;
            acc_we_s    = req_we;
            acc_idx_s   = req_addr[ADDR_BITS+1:2];
            acc_wdata_s = req_wdata;
            acc_err_s   = req_err_s;
            state_d     = S_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access_s = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (access_s) begin
      if (acc_err_s) begin
        rdata_d    = {BIT_WIDTH{1'b0}};
        resp_err_d = 1'b1;
      end else if (acc_we_s) begin
        rdata_d    = {BIT_WIDTH{1'b0}};
        resp_err_d = 1'b0;
      end else begin
        rdata_d    = ram_q[acc_idx_s];
        resp_err_d = 1'b0;
      end
    end else begin
      rdata_d    = rdata_q;
      resp_err_d = resp_err_q;
    end

    valid_d = (state_d == S_RESP);
    ready_d = (state_d == S_IDLE);
  end

  // Control and response registers; reset wins over any access on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= {ADDR_BITS{1'b0}};
      wdata_q    <= {BIT_WIDTH{1'b0}};
      err_q      <= 1'b0;
      rdata_q    <= {BIT_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      resp_err_q <= resp_err_d;
    end
  end

  // RAM contents survive reset; a write pending at a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst && access_s && acc_we_s && !acc_err_s) begin
      ram_q[acc_idx_s] <= acc_wdata_s;
    end
  end

endmodule
